// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared types for the pipeline hazard controller.
// Forward-select codes, FSM state enum and the shadow-stage entry.
package hazard_ctrl_pkg;

  localparam int SH_REG_W = 4;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [SH_REG_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic                valid;
    logic [SH_REG_W-1:0] rd;
    logic                we;
    logic                is_load;
    logic [SH_REG_W-1:0] rs;
    logic [SH_REG_W-1:0] rt;
    logic                uses_rs;
    logic                uses_rt;
  } shadow_t;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: combinational forward-select for one EX source operand.
// Ports: src_i/uses_i (EX operand), mem_*/wb_* (producer info), sel_o.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [SH_REG_W-1:0] src_i,
  input  logic                uses_i,
  input  logic                mem_valid_i,
  input  logic                mem_we_i,
  input  logic [SH_REG_W-1:0] mem_rd_i,
  input  logic                wb_valid_i,
  input  logic                wb_we_i,
  input  logic [SH_REG_W-1:0] wb_rd_i,
  output logic [1:0]          sel_o
);

  logic live;
  logic hit_mem;
  logic hit_wb;

  assign live    = uses_i & (src_i != REG_ZERO);
  assign hit_mem = live & mem_valid_i & mem_we_i
                 & (mem_rd_i == src_i);
  assign hit_wb  = live & wb_valid_i & wb_we_i
                 & (wb_rd_i == src_i);

  // MEM is younger than WB, so it wins.
  assign sel_o = hit_mem ? FWD_MEM
               : hit_wb  ? FWD_WB
               :           FWD_NONE;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use stall/bubble, branch flush.
// Ports: clk/rst, id_* decode, ex_br_ctrl; forwardA/B, stall, bubble, flush, prev_br_ctrl.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W        = 4,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             ex_br_ctrl,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic             prev_br_ctrl
);

  shadow_t   id_e;
  shadow_t   ex_d;
  shadow_t   ex_q;
  shadow_t   mem_q;
  shadow_t   wb_q;
  hz_state_e st_q;
  hz_state_e st_d;
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic      prev_q;
  logic      detect;
  logic      stall_c;
  logic      bubble_c;
  logic      flush_c;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  always_comb begin
    id_e = '0;
    if (id_valid) begin
      id_e.valid   = 1'b1;
      id_e.rd      = id_rd;
      id_e.we      = id_we;
      id_e.is_load = id_is_load;
      id_e.rs      = id_rs;
      id_e.rt      = id_rt;
      id_e.uses_rs = id_uses_rs;
      id_e.uses_rt = id_uses_rt;
    end
  end

  assign detect = id_valid & ex_q.valid & ex_q.is_load
                & ex_q.we & (ex_q.rd != REG_ZERO)
                & ((id_uses_rs & (id_rs == ex_q.rd))
                 | (id_uses_rt & (id_rt == ex_q.rd)));

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    bubble_c = 1'b0;
    flush_c  = 1'b0;
    if (ex_br_ctrl) begin
      // The consumer is squashed anyway.
      flush_c = 1'b1;
      st_d    = ST_IDLE;
      cnt_d   = 2'd0;
    end else if (st_q == ST_STALL) begin
      stall_c  = 1'b1;
      bubble_c = 1'b1;
      if (cnt_q <= 2'd1) begin
        st_d  = ST_IDLE;
        cnt_d = 2'd0;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (detect) begin
      stall_c  = 1'b1;
      bubble_c = 1'b1;
      if (LOAD_BUBBLES > 1) begin
        st_d  = ST_STALL;
        cnt_d = 2'(LOAD_BUBBLES - 1);
      end
    end
  end

  assign ex_d = (bubble_c | flush_c) ? '0 : id_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      st_q   <= ST_IDLE;
      cnt_q  <= 2'd0;
      prev_q <= 1'b0;
    end else begin
      ex_q   <= ex_d;
      mem_q  <= ex_q;
      wb_q   <= mem_q;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      prev_q <= ex_br_ctrl;
    end
  end

  fwd_sel u_fwd_rt (
    .src_i       (ex_q.rt),
    .uses_i      (ex_q.uses_rt),
    .mem_valid_i (mem_q.valid),
    .mem_we_i    (mem_q.we),
    .mem_rd_i    (mem_q.rd),
    .wb_valid_i  (wb_q.valid),
    .wb_we_i     (wb_q.we),
    .wb_rd_i     (wb_q.rd),
    .sel_o       (fwd_a)
  );

  fwd_sel u_fwd_rs (
    .src_i       (ex_q.rs),
    .uses_i      (ex_q.uses_rs),
    .mem_valid_i (mem_q.valid),
    .mem_we_i    (mem_q.we),
    .mem_rd_i    (mem_q.rd),
    .wb_valid_i  (wb_q.valid),
    .wb_we_i     (wb_q.we),
    .wb_rd_i     (wb_q.rd),
    .sel_o       (fwd_b)
  );

  // Outputs are forced low while reset is sampled.
  assign forwardA     = rst ? FWD_NONE : fwd_a;
  assign forwardB     = rst ? FWD_NONE : fwd_b;
  assign stall        = stall_c & ~rst;
  assign bubble       = bubble_c & ~rst;
  assign flush        = flush_c & ~rst;
  assign prev_br_ctrl = prev_q & ~rst;

  // A loaded value is never in MEM in time to be forwarded.
  a_no_load_fwd: assert property (
    @(posedge clk) disable iff (rst)
    !(mem_q.is_load
      && ((fwd_a == FWD_MEM) || (fwd_b == FWD_MEM)))
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector bench for hazard_ctrl.
// Two instances: LOAD_BUBBLES=1 (u1) and LOAD_BUBBLES=3 (u3).
module tb_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       urs;
    logic       urt;
    logic [3:0] rd;
    logic       we;
    logic       ld;
    logic       br;
  } in_t;

  typedef struct {
    string      nm;
    int         dut;
    in_t        in;
    logic [7:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  in_t  i1;
  in_t  i3;

  logic [1:0] fa1, fb1, fa3, fb3;
  logic st1, bu1, fl1, pv1;
  logic st3, bu3, fl3, pv3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(4), .LOAD_BUBBLES(1)) u1 (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (i1.v),
    .id_rs        (i1.rs),
    .id_rt        (i1.rt),
    .id_uses_rs   (i1.urs),
    .id_uses_rt   (i1.urt),
    .id_rd        (i1.rd),
    .id_we        (i1.we),
    .id_is_load   (i1.ld),
    .ex_br_ctrl   (i1.br),
    .forwardA     (fa1),
    .forwardB     (fb1),
    .stall        (st1),
    .bubble       (bu1),
    .flush        (fl1),
    .prev_br_ctrl (pv1)
  );

  hazard_ctrl #(.REG_W(4), .LOAD_BUBBLES(3)) u3 (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (i3.v),
    .id_rs        (i3.rs),
    .id_rt        (i3.rt),
    .id_uses_rs   (i3.urs),
    .id_uses_rt   (i3.urt),
    .id_rd        (i3.rd),
    .id_we        (i3.we),
    .id_is_load   (i3.ld),
    .ex_br_ctrl   (i3.br),
    .forwardA     (fa3),
    .forwardB     (fb3),
    .stall        (st3),
    .bubble       (bu3),
    .flush        (fl3),
    .prev_br_ctrl (pv3)
  );

  function automatic in_t nop();
    return '0;
  endfunction

  function automatic in_t add(int rd, int rs, int rt);
    in_t x = '0;
    x.v = 1'b1;
    x.rd = 4'(rd);
    x.rs = 4'(rs);
    x.rt = 4'(rt);
    x.urs = 1'b1;
    x.urt = 1'b1;
    x.we = 1'b1;
    return x;
  endfunction

  function automatic in_t lw(int rd, int rs);
    in_t x = '0;
    x.v = 1'b1;
    x.rd = 4'(rd);
    x.rs = 4'(rs);
    x.urs = 1'b1;
    x.we = 1'b1;
    x.ld = 1'b1;
    return x;
  endfunction

  function automatic in_t br(in_t x);
    in_t y = x;
    y.br = 1'b1;
    return y;
  endfunction

  // {forwardA, forwardB, stall, bubble, flush, prev_br_ctrl}
  function automatic logic [7:0] ex(logic [1:0] fa, logic [1:0] fb,
                                    logic s, logic b, logic f, logic p);
    return {fa, fb, s, b, f, p};
  endfunction

  function automatic vec_t mk(string nm, int dut, in_t in, logic [7:0] e);
    vec_t v;
    v.nm = nm;
    v.dut = dut;
    v.in = in;
    v.exp = e;
    return v;
  endfunction

  function automatic logic [7:0] out1();
    return {fa1, fb1, st1, bu1, fl1, pv1};
  endfunction

  function automatic logic [7:0] out3();
    return {fa3, fb3, st3, bu3, fl3, pv3};
  endfunction

  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b (fa fb st bu fl pv)",
               nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  logic [7:0] z;

  initial begin
    z = 8'h00;

    tbl.push_back(mk("v0",       1, add(3,1,2), z));
    tbl.push_back(mk("v1",       1, add(4,3,5), z));
    tbl.push_back(mk("raw_mem",  1, nop(),      ex(2'b00,2'b10,0,0,0,0)));
    tbl.push_back(mk("v3",       1, add(3,1,2), z));
    tbl.push_back(mk("v4",       1, nop(),      z));
    tbl.push_back(mk("v5",       1, add(6,7,3), z));
    tbl.push_back(mk("raw_wb",   1, nop(),      ex(2'b01,2'b00,0,0,0,0)));
    tbl.push_back(mk("v7",       1, add(3,1,2), z));
    tbl.push_back(mk("v8",       1, add(3,1,1), z));
    tbl.push_back(mk("v9",       1, add(8,3,3), z));
    tbl.push_back(mk("mem_prio", 1, nop(),      ex(2'b10,2'b10,0,0,0,0)));
    tbl.push_back(mk("v11",      1, lw(2,9),    z));
    tbl.push_back(mk("lu_stall", 1, add(4,2,2), ex(2'b00,2'b00,1,1,0,0)));
    tbl.push_back(mk("lu_rel",   1, add(4,2,2), z));
    tbl.push_back(mk("lu_fwdwb", 1, nop(),      ex(2'b01,2'b01,0,0,0,0)));
    tbl.push_back(mk("v15",      1, add(0,1,1), z));
    tbl.push_back(mk("v16",      1, add(5,0,0), z));
    tbl.push_back(mk("r0_fwd",   1, nop(),      z));
    tbl.push_back(mk("v18",      1, lw(0,1),    z));
    tbl.push_back(mk("r0_load",  1, add(6,0,0), z));
    tbl.push_back(mk("v20",      1, nop(),      z));
    tbl.push_back(mk("v21",      1, lw(7,1),    z));
    tbl.push_back(mk("br_vs_lu", 1, br(add(9,7,1)),
                     ex(2'b00,2'b00,0,0,1,0)));
    tbl.push_back(mk("post_br",  1, nop(),      ex(2'b00,2'b00,0,0,0,1)));
    tbl.push_back(mk("prev_clr", 1, nop(),      z));
    tbl.push_back(mk("br_only",  1, br(nop()),  ex(2'b00,2'b00,0,0,1,0)));
    tbl.push_back(mk("br_prev",  1, nop(),      ex(2'b00,2'b00,0,0,0,1)));

    tbl.push_back(mk("lb3_c0",   3, lw(2,9),    z));
    tbl.push_back(mk("lb3_st1",  3, add(4,2,2), ex(2'b00,2'b00,1,1,0,0)));
    tbl.push_back(mk("lb3_st2",  3, add(4,2,2), ex(2'b00,2'b00,1,1,0,0)));
    tbl.push_back(mk("lb3_st3",  3, add(4,2,2), ex(2'b00,2'b00,1,1,0,0)));
    tbl.push_back(mk("lb3_rel",  3, add(4,2,2), z));
    tbl.push_back(mk("lb3_rf",   3, nop(),      z));

    rst = 1'b1;
    i1 = nop();
    i3 = nop();
    next_cycle();

    // Branch and decode active while in reset: outputs must stay low.
    i1 = br(add(4,2,2));
    i3 = br(add(4,2,2));
    @(negedge clk);
    check("rst_u1", out1(), z);
    check("rst_u3", out3(), z);
    next_cycle();

    rst = 1'b0;
    i1 = nop();
    i3 = nop();
    @(negedge clk);
    check("post_rst_u1", out1(), z);
    check("post_rst_u3", out3(), z);
    next_cycle();

    foreach (tbl[k]) begin
      if (tbl[k].dut == 1) begin
        i1 = tbl[k].in;
        i3 = nop();
      end else begin
        i1 = nop();
        i3 = tbl[k].in;
      end
      @(negedge clk);
      if (tbl[k].dut == 1)
        check(tbl[k].nm, out1(), tbl[k].exp);
      else
        check(tbl[k].nm, out3(), tbl[k].exp);
      next_cycle();
    end

    // Reset taken while u3 is in the middle of a 3-cycle stall.
    i1 = nop();
    i3 = lw(2,9);
    next_cycle();
    i3 = add(4,2,2);
    @(negedge clk);
    check("rst_pre", out3(), ex(2'b00,2'b00,1,1,0,0));
    next_cycle();
    @(negedge clk);
    check("rst_st2", out3(), ex(2'b00,2'b00,1,1,0,0));
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid", out3(), z);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_after", out3(), z);
    next_cycle();
    i3 = nop();
    @(negedge clk);
    check("rst_nofwd", out3(), z);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core. Drives the EX-stage forwarding selects, load-use stalls/bubbles, branch flushes and the one-cycle post-branch flag-suppress signal.
- Keeps a private shadow pipeline of destination/source register info for the EX, MEM and WB stages. All decisions come from registered state plus the current ID-stage decode.

Parameters:
- REG_W, 4, register-address width (16 GPRs; R0 hardwired zero).
- LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (legal 1..3).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_W  src0 (p0) register address.
- id_rt  in  REG_W  src1 (p1) register address.
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_rd  in  REG_W  destination register.
- id_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is LW.
- ex_br_ctrl  in  1  branch/jump taken, resolved in EX this cycle.
- forwardA  out  2  src1 select: 10 = MEM ALU result, 01 = WB data, 00 = p1.
- forwardB  out  2  src0 select, same encoding, p0.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  load NOP into ID/EX.
- flush  out  1  squash IF/ID and ID/EX.
- prev_br_ctrl  out  1  ex_br_ctrl delayed one cycle (ALU flag-update suppress).

Behaviour:
- Shadow entry per stage (EX, MEM, WB): {valid, rd, we, is_load, rs, rt, uses_rs, uses_rt}.
- Advance every cycle: WB<=MEM, MEM<=EX, EX<=ID entry. The EX entry loads invalid when bubble or flush is asserted.
- Reset: all entries valid=0, stall counter=0, state IDLE, prev_br_ctrl=0. Every output is 0 during reset and in the first cycle after it.
- Forwarding is combinational from the EX/MEM/WB shadow registers. For the EX operand src1 (rt):
  - 10 if MEM.valid & MEM.we & MEM.rd==EX.rt & EX.rt!=0 & EX.uses_rt.
  - else 01 if the same condition holds against WB.
  - else 00.
- forwardB uses the same rules on rs. MEM has priority over WB, so 11 is never produced.
- 10 must never select a MEM entry with is_load=1. This is guaranteed by the stall logic and checked by an assertion.
- Load-use detect (combinational): id_valid & EX.valid & EX.is_load & EX.we & EX.rd!=0 & ((id_uses_rs & id_rs==EX.rd) | (id_uses_rt & id_rt==EX.rd)).
- FSM IDLE/STALL, with a 2-bit counter cnt:
  - IDLE, detect & !ex_br_ctrl: stall=1, bubble=1. If LOAD_BUBBLES>1, go to STALL with cnt=LOAD_BUBBLES-1; otherwise stay in IDLE.
  - STALL: stall=1, bubble=1, cnt decrements. Return to IDLE when cnt reaches 1.
  - Any state, ex_br_ctrl=1: flush=1, stall=0, bubble=0. Next state IDLE, cnt=0. Flush beats stall.
- Register file writes through in the same cycle, so stalled ID re-reads obtain WB data. No forwarding beyond WB is required.
- flush is combinational from ex_br_ctrl: one-cycle pulse, both younger instructions squashed. The EX entry loads invalid; MEM receives the branch entry normally.
- prev_br_ctrl <= ex_br_ctrl each cycle.
- Simultaneous detect and branch: no stall, flush only. The consumer is squashed.
- Reset mid-stall: the FSM returns to IDLE and stall deasserts in the same cycle rst is sampled.

Decomposition:
- Shared package holds:
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the hazard FSM state enum;
  - the shadow-entry struct typedef;
  - REG_ZERO=0.
- One natural sub-module, fwd_sel: a purely combinational comparator instantiated twice, for rs and rt, against MEM/WB entries.

Test Plan:
- ADD R3 <- R1,R2 then ADD R4 <- R3,R5 back-to-back -> second in EX: forwardB=10, forwardA=00, no stall.
- ADD R3; NOP; SUB R6 <- R7,R3 -> SUB in EX: forwardA=01.
- LW R2 then ADD R4 <- R2,R2 (LOAD_BUBBLES=1) -> one cycle stall=1, bubble=1. Next cycle forwardA=forwardB=01, never 10.
- LOAD_BUBBLES=3, same sequence -> stall high exactly 3 consecutive cycles, then 00 selects (regfile path).
- Write to R0 followed by a reader of R0 -> forwardA/B stay 00. LW R0 + reader -> no stall.
- Taken branch in EX while load-use detected in ID -> flush=1, stall=0. Next cycle prev_br_ctrl=1, EX entry invalid. rst asserted during STALL -> stall=0 in that cycle.
